gf2m8_vec_mul: RTL and testbench

- Scalar-by-vector multiplier over GF(2^8) for the Reed-Solomon decoder datapath.
- Used by the key-equation solver, where one leading coefficient scales all coefficients of a polynomial register.
- Multiplies one 8-bit scalar by LANES 8-bit elements in parallel.
- Has an optional enable-gated output register. This register replaces the clock-gating cell: "ena low" means hold.

---
 rtl/gf_pkg.sv | 21 ++
 rtl/gf2m8_mul_core.sv | 28 ++
 rtl/gf2m8_vec_mul.sv | 48 ++++
 tb/tb_gf2m8_vec_mul.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/gf_pkg.sv
// Shared GF(2^8) definitions for the Reed-Solomon datapath: field polynomial,
// element type and a reference multiply used by models.
package gf_pkg;

  localparam logic [8:0] GF_POLY = 9'h11D;

  typedef logic [7:0] gf_byte_t;

  function automatic gf_byte_t gf_mul(input gf_byte_t a, input gf_byte_t b);
    gf_byte_t acc;
    gf_byte_t sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? GF_POLY[7:0] : 8'h00);
    end
    return acc;
  endfunction

endpackage

// File: rtl/gf2m8_mul_core.sv
// Single 8x8 GF(2^8) multiplier, p = a (*) b mod POLY.
// Latency: combinational. Backpressure: none, pure function of a and b.
// Reduction is folded into each alpha step so no 15-bit intermediate exists.
module gf2m8_mul_core
  import gf_pkg::*;
#(
  parameter logic [8:0] POLY = GF_POLY
) (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);

  gf_byte_t acc;
  gf_byte_t sh;

  always_comb begin
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      // multiply by alpha: shift, fold the x^8 term back via the low poly bits
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? POLY[7:0] : 8'h00);
    end
    p = acc;
  end

endmodule

// File: rtl/gf2m8_vec_mul.sv
// Scalar-by-vector GF(2^8) multiply: every lane of y scaled by x.
// Latency: 1 cycle (REG_OUT=1) or 0 (REG_OUT=0). Backpressure: none; ena low holds z.
// z_vld marks a freshly captured result and is never sticky.
module gf2m8_vec_mul
  import gf_pkg::*;
#(
  parameter int         LANES   = 6,
  parameter logic [8:0] POLY    = GF_POLY,
  parameter bit         REG_OUT = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [7:0]         x,
  input  logic [LANES*8-1:0] y,
  output logic [LANES*8-1:0] z,
  output logic               z_vld
);

  logic [LANES*8-1:0] prod;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    gf2m8_mul_core #(.POLY(POLY)) u_mul (
      .a (x),
      .b (y[i*8 +: 8]),
      .p (prod[i*8 +: 8])
    );
  end

  if (REG_OUT) begin : g_reg
    // enable-gated register stands in for a clock-gating cell
    always_ff @(posedge clk) begin
      if (rst) begin
        z     <= '0;
        z_vld <= 1'b0;
      end else begin
        z_vld <= ena;
        if (ena) z <= prod;
      end
    end
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign z              = prod;
    assign z_vld          = ena;
  end

endmodule

// File: tb/tb_gf2m8_vec_mul.sv
// Self-checking bench for gf2m8_vec_mul: registered and combinational builds
// driven in parallel, checked against a clmul-then-divide field model.
module tb_gf2m8_vec_mul;

  localparam int         LANES = 6;
  localparam logic [8:0] POLY  = 9'h11D;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               ena = 1'b0;
  logic [7:0]         x   = '0;
  logic [LANES*8-1:0] y   = '0;
  logic [LANES*8-1:0] z_r, z_c;
  logic               z_vld_r, z_vld_c;

  int  n_vec  = 0;
  int  n_fail = 0;
  bit  chk_en = 1'b0;

  logic [7:0] exp_z [LANES];
  logic       exp_vld = 1'b0;

  always #5 clk = ~clk;

  gf2m8_vec_mul #(.LANES(LANES), .POLY(POLY), .REG_OUT(1'b1)) dut_r (
    .clk(clk), .rst(rst), .ena(ena), .x(x), .y(y), .z(z_r), .z_vld(z_vld_r)
  );

  gf2m8_vec_mul #(.LANES(LANES), .POLY(POLY), .REG_OUT(1'b0)) dut_c (
    .clk(clk), .rst(rst), .ena(ena), .x(x), .y(y), .z(z_c), .z_vld(z_vld_c)
  );

  // Model: full carry-less product, then polynomial long division by POLY.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (15'(a) << i);
    for (int d = 14; d >= 8; d--)
      if (p[d]) p = p ^ (15'(POLY) << (d - 8));
    return p[7:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycle model of the registered build.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) exp_z[i] = 8'h00;
      exp_vld = 1'b0;
    end else begin
      exp_vld = ena;
      if (ena)
        for (int i = 0; i < LANES; i++) exp_z[i] = ref_mul(y[i*8 +: 8], x);
    end
  end

  // Single compare process, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < LANES; i++)
        check($sformatf("reg_lane%0d", i), 64'(z_r[i*8 +: 8]), 64'(exp_z[i]));
      check("reg_vld", 64'(z_vld_r), 64'(exp_vld));
    end
    for (int i = 0; i < LANES; i++)
      check($sformatf("comb_lane%0d", i), 64'(z_c[i*8 +: 8]), 64'(ref_mul(y[i*8 +: 8], x)));
    check("comb_vld", 64'(z_vld_c), 64'(ena));
  end

  logic [LANES*8-1:0] known_z;
  logic [LANES*8-1:0] all13;

  initial begin
    known_z = {8'hE3, 8'h3A, 8'h00, 8'h02, 8'h01, 8'h1D};
    all13   = {LANES{8'h13}};

    // pin the model with hand-computed values
    check("model_02x80", 64'(ref_mul(8'h02, 8'h80)), 64'h1D);
    check("model_80x02", 64'(ref_mul(8'h80, 8'h02)), 64'h1D);
    check("model_80x80", 64'(ref_mul(8'h80, 8'h80)), 64'h13);
    check("model_02x8E", 64'(ref_mul(8'h02, 8'h8E)), 64'h01);
    check("model_1Dx02", 64'(ref_mul(8'h1D, 8'h02)), 64'h3A);
    check("model_02xFF", 64'(ref_mul(8'h02, 8'hFF)), 64'hE3);

    // reset with ena high and all-ones inputs
    rst = 1'b1; ena = 1'b1; x = 8'hFF; y = '1;
    step();
    chk_en = 1'b1;
    step();
    check("rst_z", 64'(z_r), 64'h0);
    check("rst_vld", 64'(z_vld_r), 64'h0);
    rst = 1'b0; ena = 1'b0;
    step();
    check("post_rst_z", 64'(z_r), 64'h0);

    // known products: one-cycle pulse
    x = 8'h02;
    y = {8'hFF, 8'h1D, 8'h00, 8'h01, 8'h8E, 8'h80};
    ena = 1'b1;
    #1;
    check("comb_known_z", 64'(z_c), 64'(known_z));
    check("comb_known_vld", 64'(z_vld_c), 64'h1);
    step();
    check("known_z", 64'(z_r), 64'(known_z));
    check("known_vld", 64'(z_vld_r), 64'h1);
    ena = 1'b0;
    step();
    check("known_vld_drop", 64'(z_vld_r), 64'h0);

    // hold while inputs churn
    for (int k = 0; k < 10; k++) begin
      x = 8'($urandom);
      y = LANES*8'({$urandom, $urandom});
      step();
    end
    check("hold_z", 64'(z_r), 64'(known_z));
    check("hold_vld", 64'(z_vld_r), 64'h0);

    // square
    x = 8'h80; y = {LANES{8'h80}}; ena = 1'b1;
    step();
    check("square_z", 64'(z_r), 64'(all13));

    // streaming with reset on the fifth cycle
    y = {LANES{8'h01}};
    for (int k = 1; k <= 8; k++) begin
      x = 8'(8'h30 + k);
      rst = (k == 5);
      step();
      if (k == 5) begin
        check("stream_rst_z", 64'(z_r), 64'h0);
        check("stream_rst_vld", 64'(z_vld_r), 64'h0);
      end else begin
        check($sformatf("stream_z%0d", k), 64'(z_r), 64'({LANES{8'(8'h30 + k)}}));
        check($sformatf("stream_vld%0d", k), 64'(z_vld_r), 64'h1);
      end
    end
    rst = 1'b0;

    // exhaustive pairs: DUT x*y against model y*x, plus the package reference
    for (int a = 0; a < 256; a++) begin
      for (int base = 0; base < 256; base += LANES) begin
        x = 8'(a);
        for (int i = 0; i < LANES; i++) begin
          y[i*8 +: 8] = 8'(base + i);
          if (base + i < 256)
            check("pkg_gf_mul", 64'(gf_pkg::gf_mul(8'(a), 8'(base + i))),
                  64'(ref_mul(8'(base + i), 8'(a))));
        end
        ena = 1'b1;
        step();
      end
    end
    ena = 1'b0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
